// File: rtl/register_scoreboard_pkg.sv
// rtl/register_scoreboard_pkg.sv - shared types and sizing for the register scoreboard
package register_scoreboard_pkg;

    localparam int REGISTER_COUNT = 32;
    localparam int MAX_PENDING    = 3;
    localparam int TAG_WIDTH      = $clog2(REGISTER_COUNT);
    localparam int COUNT_WIDTH    = $clog2(MAX_PENDING + 1);
    localparam int TOTAL_WIDTH    = $clog2(REGISTER_COUNT * MAX_PENDING + 1);

    typedef logic [TAG_WIDTH-1:0] tag;
    typedef logic [31:0]          word_address;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } scoreboard_state;

endpackage

// File: rtl/register_scoreboard_pending_counter.sv
// rtl/register_scoreboard_pending_counter.sv - per-register in-flight write counter
module pending_counter #(
    parameter int MAX_PENDING = 3,
    localparam int CW = $clog2(MAX_PENDING + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inc,
    input  logic          wb,
    input  logic          kill,
    output logic [CW-1:0] count_next,
    output logic          pending,
    output logic          busy,
    output logic          full,
    output logic          underflow
);
    import register_scoreboard_pkg::*;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW:0]   up;
    logic [CW:0]   down;
    logic [CW:0]   diff;

    always_comb begin
        up        = {1'b0, count_q} + (CW+1)'(inc);
        down      = (CW+1)'(wb) + (CW+1)'(kill);
        diff      = up - down;
        count_d   = count_q;
        underflow = 1'b0;
        if (down > up) begin
            count_d   = '0;
            underflow = 1'b1;
        end else if (diff > (CW+1)'(MAX_PENDING)) begin
            count_d = CW'(MAX_PENDING);
        end else begin
            count_d = diff[CW-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Same-cycle releases already count as written: the register file is write-through.
    assign busy       = {1'b0, count_q} > down;
    assign full       = count_q == CW'(MAX_PENDING);
    assign pending    = count_q != '0;
    assign count_next = count_d;

endmodule

// File: rtl/register_scoreboard.sv
// rtl/register_scoreboard.sv - RAW/WAW issue gating and fence drain for in-flight register writes
module register_scoreboard #(
    parameter int REGISTER_COUNT = 32,
    parameter int MAX_PENDING    = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          issue_valid,
    input  register_scoreboard_pkg::tag   rs1,
    input  register_scoreboard_pkg::tag   rs2,
    input  register_scoreboard_pkg::tag   rd,
    input  logic                          uses_rs1,
    input  logic                          uses_rs2,
    input  logic                          writes_rd,
    input  logic                          flush,
    input  logic                          writeback_valid,
    input  register_scoreboard_pkg::tag   writeback_rd,
    input  logic                          kill_valid,
    input  register_scoreboard_pkg::tag   kill_rd,
    input  logic                          fence_req,
    output logic                          stall,
    output logic                          issue_accept,
    output logic [REGISTER_COUNT-1:0]     pending_mask,
    output logic                          idle,
    output logic                          fence_done,
    output logic                          underflow_error
);
    import register_scoreboard_pkg::*;

    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam int TW = $clog2(REGISTER_COUNT * MAX_PENDING + 1);
    localparam int GW = $bits(tag);

    logic [CW-1:0]             count_next [REGISTER_COUNT];
    logic [REGISTER_COUNT-1:0] busy_vec;
    logic [REGISTER_COUNT-1:0] full_vec;
    logic [REGISTER_COUNT-1:0] under_vec;
    logic [REGISTER_COUNT-1:0] pend_vec;

    logic [TW-1:0]   total_q, total_d;
    logic            underflow_q, underflow_d;
    scoreboard_state state_q, state_d;
    logic            raw_hazard, waw_hazard;

    // x0 is hardwired: never pending, never busy, never full.
    assign count_next[0] = '0;
    assign busy_vec[0]   = 1'b0;
    assign full_vec[0]   = 1'b0;
    assign under_vec[0]  = 1'b0;
    assign pend_vec[0]   = 1'b0;

    for (genvar r = 1; r < REGISTER_COUNT; r++) begin : g_cnt
        logic inc_r, wb_r, kill_r;
        assign inc_r  = issue_accept & writes_rd & (rd == GW'(r));
        assign wb_r   = writeback_valid & (writeback_rd == GW'(r));
        assign kill_r = kill_valid & (kill_rd == GW'(r));

        pending_counter #(.MAX_PENDING(MAX_PENDING)) u_cnt (
            .clock      (clock),
            .reset      (reset),
            .inc        (inc_r),
            .wb         (wb_r),
            .kill       (kill_r),
            .count_next (count_next[r]),
            .pending    (pend_vec[r]),
            .busy       (busy_vec[r]),
            .full       (full_vec[r]),
            .underflow  (under_vec[r])
        );
    end

    always_comb begin
        raw_hazard   = (uses_rs1 & busy_vec[rs1]) | (uses_rs2 & busy_vec[rs2]);
        // Checked against the pre-release count so a same-cycle writeback never opens a slot.
        waw_hazard   = writes_rd & (rd != '0) & full_vec[rd];
        stall        = issue_valid & (raw_hazard | waw_hazard | (state_q != IDLE));
        issue_accept = issue_valid & ~stall & ~flush;
    end

    always_comb begin
        total_d = '0;
        for (int i = 1; i < REGISTER_COUNT; i++) begin
            total_d = total_d + TW'(count_next[i]);
        end
        underflow_d = underflow_q | (|under_vec);
    end

    always_comb begin
        state_d    = state_q;
        fence_done = 1'b0;
        case (state_q)
            IDLE:  if (fence_req) state_d = DRAIN;
            DRAIN: if (total_d == '0) state_d = DONE;
            DONE: begin
                fence_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            total_q     <= '0;
            underflow_q <= 1'b0;
            state_q     <= IDLE;
        end else begin
            total_q     <= total_d;
            underflow_q <= underflow_d;
            state_q     <= state_d;
        end
    end

    assign pending_mask    = pend_vec;
    assign idle            = total_q == '0;
    assign underflow_error = underflow_q;

endmodule
